// File: rtl/uart_pkg.sv
// uart_pkg
//   Constants and types shared by the UART receiver and transmitter.
//   OVERSAMPLE : oversample ticks per bit period
//   MID_SAMPLE : tick index (1-based) at which the start bit is re-checked
//   rx_state_t : receiver FSM state encoding
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_tick.sv
// uart_rx_tick
//   Oversample tick generator. Counts 0..div and pulses tick for one CLK
//   when the count equals div, then wraps to 0. div = 0 ticks every CLK.
//   Ports:
//     CLK    : system clock
//     HRESET : asynchronous active-high reset
//     clear  : synchronous restart of the count (suppresses tick)
//     div    : CLK cycles per tick minus 1
//     tick   : one-CLK pulse per oversample period
module uart_rx_tick (
    input  logic        CLK,
    input  logic        HRESET,
    input  logic        clear,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt_reg;
    logic [15:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg + 16'd1;
        if (clear || (cnt_reg == div)) begin
            cnt_next = 16'd0;
        end
    end

    assign tick = !clear && (cnt_reg == div);

    always_ff @(posedge CLK or posedge HRESET) begin
        if (HRESET) begin
            cnt_reg <= 16'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   16x oversampling UART receiver with a single-entry output register and
//   valid/ready handshake.
//   Parameters:
//     DATA_BITS   : data bits per frame (5..8)
//     SYNC_STAGES : rxd synchronizer depth (>= 2)
//   Ports:
//     CLK       : system clock
//     HRESET    : asynchronous active-high reset
//     baud_div  : CLK cycles per oversample tick minus 1
//     rxd       : asynchronous serial input, idle high
//     rx_data   : received word, LSB = first data bit
//     rx_valid  : rx_data holds an unconsumed word
//     rx_ready  : consumer takes rx_data this cycle
//     frame_err : one-cycle pulse when the stop bit samples 0
//     overrun   : one-cycle pulse when a completed word is dropped
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 HRESET,
    input  logic [15:0]          baud_div,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam logic [3:0] OS_MID   = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Input synchronizer (resets to the idle level so reset release never
    // looks like a start edge)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   rxd_s;
    logic                   rxd_prev_reg;
    logic                   start_edge;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = rxd;
            end else begin : g_next
                assign sync_d[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge CLK or posedge HRESET) begin
        if (HRESET) begin
            sync_reg     <= '1;
            rxd_prev_reg <= 1'b1;
        end else begin
            sync_reg     <= sync_d;
            rxd_prev_reg <= rxd_s;
        end
    end

    assign rxd_s = sync_reg[SYNC_STAGES-1];
    // A line that stays low (break) never produces another edge, so the
    // receiver only re-arms once the line has gone back high.
    assign start_edge = rxd_prev_reg && !rxd_s;

    // ------------------------------------------------------------------
    // Datapath and FSM declarations
    // ------------------------------------------------------------------
    rx_state_t             state_reg;
    rx_state_t             state_next;
    logic [3:0]            os_cnt_reg;
    logic [3:0]            bit_cnt_reg;
    logic [DATA_BITS-1:0]  shift_reg;
    logic [DATA_BITS-1:0]  rx_data_reg;
    logic [15:0]           div_lat_reg;
    logic                  rx_valid_reg;
    logic                  frame_err_reg;
    logic                  overrun_reg;

    logic tick;
    logic tick_clear;
    logic load_div;
    logic sample_pt;
    logic shift_en;
    logic frame_ok;
    logic frame_bad;

    // Divider is latched at the start edge so a baud change mid-frame
    // only applies to the next frame.
    uart_rx_tick u_tick (
        .CLK    (CLK),
        .HRESET (HRESET),
        .clear  (tick_clear),
        .div    (div_lat_reg),
        .tick   (tick)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg <= RX_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RX_IDLE: begin
                if (start_edge) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                if (tick && (os_cnt_reg == OS_MID)) begin
                    // High at mid-start means a glitch: drop back silently.
                    state_next = rxd_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick && (os_cnt_reg == OS_LAST) && (bit_cnt_reg == BIT_LAST)) begin
                    state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick && (os_cnt_reg == OS_LAST)) begin
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        tick_clear = 1'b0;
        load_div   = 1'b0;
        sample_pt  = 1'b0;
        shift_en   = 1'b0;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                // Hold the tick counter at 0 so START begins a fresh period.
                tick_clear = 1'b1;
                load_div   = start_edge;
            end
            RX_START: begin
                sample_pt = tick && (os_cnt_reg == OS_MID);
            end
            RX_DATA: begin
                sample_pt = tick && (os_cnt_reg == OS_LAST);
                shift_en  = sample_pt;
            end
            RX_STOP: begin
                sample_pt = tick && (os_cnt_reg == OS_LAST);
                frame_ok  = sample_pt && rxd_s;
                frame_bad = sample_pt && !rxd_s;
            end
            default: begin
                tick_clear = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, shifter, divider latch
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge HRESET) begin
        if (HRESET) begin
            os_cnt_reg  <= 4'd0;
            bit_cnt_reg <= 4'd0;
            shift_reg   <= '0;
            div_lat_reg <= 16'd0;
        end else begin
            if (load_div) begin
                div_lat_reg <= baud_div;
            end
            if (state_reg == RX_IDLE) begin
                os_cnt_reg  <= 4'd0;
                bit_cnt_reg <= 4'd0;
            end else if (tick) begin
                os_cnt_reg <= sample_pt ? 4'd0 : os_cnt_reg + 4'd1;
            end
            if (shift_en) begin
                // LSB-first: each new bit enters at the top and walks down.
                shift_reg   <= {rxd_s, shift_reg[DATA_BITS-1:1]};
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register and handshake
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge HRESET) begin
        if (HRESET) begin
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= frame_bad;
            overrun_reg   <= 1'b0;
            if (frame_ok) begin
                // A handshake in the same cycle frees the slot for the new word.
                if (!rx_valid_reg || rx_ready) begin
                    rx_data_reg  <= shift_reg;
                    rx_valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    import uart_pkg::*;

    logic        CLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [15:0] baud_div = 16'd3;
    logic        rxd = 1'b1;
    logic        rx_ready = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        overrun;

    uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .CLK       (CLK),
        .HRESET    (HRESET),
        .baud_div  (baud_div),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int n_err_pulse = 0;
    int n_ovr_pulse = 0;
    int n_valid_cyc = 0;
    int n_delivered = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sb_exp;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: samples mid-cycle, pops on every handshake.
    always @(negedge CLK) begin
        if (!HRESET) begin
            if (frame_err) n_err_pulse++;
            if (overrun)   n_ovr_pulse++;
            if (rx_valid)  n_valid_cyc++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_byte", 32'(rx_valid), 32'd0);
                end else begin
                    sb_exp = exp_q.pop_front();
                    $display("rx byte 0x%02h expected 0x%02h", rx_data, sb_exp);
                    check_val("rx_data", {24'd0, rx_data}, {24'd0, sb_exp});
                    n_delivered++;
                end
            end
        end
    end

    // All stimulus runs at posedge+2 so inputs never change near an edge.
    task automatic wait_clk(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic tx_bit(input logic b, input int n);
        rxd = b;
        wait_clk(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bp);
        tx_bit(1'b0, bp);
        for (int i = 0; i < 8; i++) tx_bit(d[i], bp);
        tx_bit(stop, bp);
    endtask

    task automatic clr_counts();
        n_err_pulse = 0;
        n_ovr_pulse = 0;
        n_valid_cyc = 0;
        n_delivered = 0;
    endtask

    localparam int BP  = 64;   // baud_div = 3
    localparam int BP7 = 128;  // baud_div = 7

    initial begin
        wait_clk(3);
        check_val("reset_rx_valid",  32'(rx_valid),  32'd0);
        check_val("reset_frame_err", 32'(frame_err), 32'd0);
        check_val("reset_overrun",   32'(overrun),   32'd0);
        check_val("reset_rx_data",   {24'd0, rx_data}, 32'd0);
        HRESET = 1'b0;
        wait_clk(20);

        // Basic frame
        clr_counts();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, BP);
        wait_clk(BP);
        check_val("a5_delivered",  32'(n_delivered), 32'd1);
        check_val("a5_valid_cyc",  32'(n_valid_cyc), 32'd1);
        check_val("a5_frame_err",  32'(n_err_pulse), 32'd0);

        // Short glitch on the line
        clr_counts();
        tx_bit(1'b0, 20);
        tx_bit(1'b1, BP + 20);
        check_val("glitch_state",    32'(dut.state_reg), 32'(RX_IDLE));
        check_val("glitch_valid",    32'(n_valid_cyc), 32'd0);
        check_val("glitch_err",      32'(n_err_pulse), 32'd0);
        check_val("glitch_ovr",      32'(n_ovr_pulse), 32'd0);

        // Stop bit 0, then a good frame
        clr_counts();
        send_frame(8'h3C, 1'b0, BP);
        tx_bit(1'b1, 2 * BP);
        check_val("ferr_pulses", 32'(n_err_pulse), 32'd1);
        check_val("ferr_valid",  32'(n_valid_cyc), 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, BP);
        wait_clk(BP);
        check_val("after_ferr_delivered", 32'(n_delivered), 32'd1);
        check_val("after_ferr_err",       32'(n_err_pulse), 32'd1);

        // Overrun with consumer stalled
        clr_counts();
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, BP);
        wait_clk(BP);
        send_frame(8'h22, 1'b1, BP);
        wait_clk(BP);
        check_val("ovr_rx_data",   {24'd0, rx_data}, 32'h11);
        check_val("ovr_rx_valid",  32'(rx_valid),    32'd1);
        check_val("ovr_pulses",    32'(n_ovr_pulse), 32'd1);
        rx_ready = 1'b1;
        wait_clk(3);
        check_val("ovr_valid_drop", 32'(rx_valid),    32'd0);
        check_val("ovr_delivered",  32'(n_delivered), 32'd1);

        // Reset mid-DATA of 0x55
        clr_counts();
        tx_bit(1'b0, BP);
        tx_bit(1'b1, BP);
        tx_bit(1'b0, BP);
        tx_bit(1'b1, BP / 2);
        HRESET = 1'b1;
        rxd = 1'b1;
        wait_clk(2);
        check_val("midrst_valid", 32'(rx_valid), 32'd0);
        HRESET = 1'b0;
        wait_clk(2 * BP);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, BP);
        wait_clk(BP);
        check_val("midrst_delivered", 32'(n_delivered), 32'd1);
        check_val("midrst_err",       32'(n_err_pulse), 32'd0);
        check_val("midrst_ovr",       32'(n_ovr_pulse), 32'd0);

        // Back-to-back frames with a divider change mid-frame
        clr_counts();
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        tx_bit(1'b0, BP);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) baud_div = 16'd7;
            tx_bit(1'b1, BP);
        end
        tx_bit(1'b1, BP);
        send_frame(8'h00, 1'b1, BP7);
        wait_clk(BP7);
        check_val("baud_delivered", 32'(n_delivered), 32'd2);
        check_val("baud_err",       32'(n_err_pulse), 32'd0);
        check_val("baud_ovr",       32'(n_ovr_pulse), 32'd0);

        check_val("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
